// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Multiplexed 7-segment scan controller for NUM_DIGITS digits.
//   A frame offered on frame_in/frame_valid is captured into a pending buffer.
//   It is copied to the displayed (shadow) buffer only at a frame boundary, so
//   a scan never mixes two frames. Each digit slot starts with an
//   anti-ghosting blank gap. The ON window is then brightness*STEP_CYCLES long,
//   and the rest of the slot is dark.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       0: scan halted, counters parked at digit 0 / phase 0
//   frame_in     digit i pattern = frame_in[7*i +: 7], 1 = segment lit
//   frame_valid  frame_in offered
//   frame_ready  pending buffer free; transfer when valid & ready
//   blank_mask   bit i forces digit i dark
//   brightness   ON time in STEP_CYCLES units (0 = dark)
//   displayout   segment pins, polarity per SEG_ACT_LOW
//   selector     one-hot digit enables, polarity per SEL_ACT_LOW
//   frame_start  1-cycle pulse on the first output cycle of the digit 0 slot
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 8,
  parameter int STEP_CYCLES  = 84,
  parameter int SEG_ACT_LOW  = 1,
  parameter int SEL_ACT_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] frame_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [3:0]              brightness,
  output logic [6:0]              displayout,
  output logic [NUM_DIGITS-1:0]   selector,
  output logic                    frame_start
);

  localparam int SLOT = BLANK_CYCLES + 16 * STEP_CYCLES;
  localparam int PW   = $clog2(SLOT);
  localparam int DW   = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PHASE_LAST = PW'(SLOT - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  // Inactive pin levels; active values are produced by XOR with these.
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    REG_BLANK,
    REG_ON,
    REG_OFF
  } region_t;

  logic [PW-1:0]           phase_q;
  logic [DW-1:0]           digit_q;
  logic [3:0]              bri_q;
  logic                    mask_q;
  logic [7*NUM_DIGITS-1:0] pending_q;
  logic [7*NUM_DIGITS-1:0] shadow_q;

  logic                    phase_wrap;
  logic                    boundary;
  logic                    apply_pending;
  logic [PW-1:0]           on_end;
  region_t                 region;
  logic [6:0]              cur_pat;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic [6:0]              seg_nxt;

  assign phase_wrap    = (phase_q == PHASE_LAST);
  assign boundary      = enable && phase_wrap && (digit_q == DIGIT_LAST);
  // A pending frame becomes visible at a frame boundary, or at once while
  // the scan is halted because nothing is being displayed then.
  assign apply_pending = !frame_ready && (boundary || !enable);

  // ---------------------------------------------------------------------------
  // Scan counters and per-slot sampled controls
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      digit_q <= '0;
      bri_q   <= '0;
      mask_q  <= 1'b0;
    end else begin
      if (!enable) begin
        phase_q <= '0;
        digit_q <= '0;
      end else if (phase_wrap) begin
        phase_q <= '0;
        digit_q <= (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
      end else begin
        phase_q <= phase_q + 1'b1;
      end

      // Phase 0 always lies in the blank gap, so latching here keeps the
      // whole visible part of the slot on one brightness/mask value.
      if (phase_q == '0) begin
        bri_q  <= brightness;
        mask_q <= blank_mask[digit_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame handshake: pending buffer -> shadow buffer
  // ---------------------------------------------------------------------------
  // NOTE: pending_q has no reset; it is only read while frame_ready is low,
  // and frame_ready is reset. shadow_q is reset because it is displayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ready <= 1'b1;
      shadow_q    <= '0;
    end else if (apply_pending) begin
      shadow_q    <= pending_q;
      frame_ready <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      pending_q <= frame_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the current counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    region  = REG_OFF;
    sel_nxt = SEL_OFF;
    seg_nxt = SEG_OFF;
    on_end  = BLANK_END + PW'(bri_q) * PW'(STEP_CYCLES);
    cur_pat = shadow_q[7*int'(digit_q) +: 7];

    if (phase_q < BLANK_END) begin
      region = REG_BLANK;
    end else if (phase_q < on_end) begin
      region = REG_ON;
    end

    if (enable && !mask_q && (region == REG_ON)) begin
      sel_nxt = SEL_OFF ^ (NUM_DIGITS'(1) << digit_q);
      seg_nxt = SEG_OFF ^ cur_pat;
    end
  end

  // Registered pins: they show the counters' decode one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      selector    <= SEL_OFF;
      displayout  <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      selector    <= sel_nxt;
      displayout  <= seg_nxt;
      frame_start <= enable && (phase_q == '0) && (digit_q == '0);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int BC    = 2;
  localparam int SC    = 1;
  localparam int SLOT  = 18;
  localparam int FRAME = ND * SLOT;

  typedef logic [6:0] pats_t [4];

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [27:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
  logic [6:0]  displayout;
  logic [3:0]  selector;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame A = 28'h0FEDCBA split into 7-bit digits, digit 0 in the low bits.
  localparam logic [27:0] FRAME_A = 28'h0FEDCBA;
  localparam logic [27:0] FRAME_B = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] FRAME_C = {7'h7F, 7'h01, 7'h40, 7'h55};
  pats_t pats_a = '{7'h3A, 7'h39, 7'h7B, 7'h07};
  pats_t pats_b = '{7'h06, 7'h5B, 7'h4F, 7'h66};
  pats_t pats_c = '{7'h55, 7'h40, 7'h01, 7'h7F};
  pats_t pats_0 = '{7'h00, 7'h00, 7'h00, 7'h00};

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .BLANK_CYCLES(BC),
    .STEP_CYCLES (SC),
    .SEG_ACT_LOW (1),
    .SEL_ACT_LOW (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .blank_mask (blank_mask),
    .brightness (brightness),
    .displayout (displayout),
    .selector   (selector),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string name);
    n_tests++;
    if (selector !== 4'b0000 || displayout !== 7'h7F || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: sel=%b seg=%h fs=%b, expected sel=0000 seg=7f fs=0",
               name, selector, displayout, frame_start);
    end
  endtask

  task automatic expect_ready(input string name, input logic exp);
    n_tests++;
    if (frame_ready !== exp) begin
      n_fail++;
      $display("FAIL %s: frame_ready=%b expected %b", name, frame_ready, exp);
    end
  endtask

  task automatic expect_fs(input string name);
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_start=%b expected 1", name, frame_start);
    end
  endtask

  // Advance until frame_start is seen (at least one clock), bounded.
  task automatic wait_frame_start(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_start not seen in 200 cycles (got %b, expected 1)",
               name, frame_start);
    end
  endtask

  // Checks one full frame starting at the sample where frame_start is high.
  // Ends on the first sample of the following frame. When inject_k >= 0, a
  // new frame is offered right after sample inject_k.
  task automatic check_frame(input pats_t pats, input int bri, input logic [3:0] mask,
                             input int inject_k, input logic [27:0] inj_frame,
                             input string name);
    for (int k = 0; k < FRAME; k++) begin
      int d;
      int p;
      logic act;
      logic [3:0] sel_exp;
      logic [6:0] seg_exp;
      d   = k / SLOT;
      p   = k % SLOT;
      act = !mask[d] && (p >= BC) && (p < BC + bri * SC);
      sel_exp = act ? (4'b0001 << d) : 4'b0000;
      seg_exp = act ? ~pats[d] : 7'h7F;
      n_tests++;
      if (selector !== sel_exp || displayout !== seg_exp) begin
        n_fail++;
        $display("FAIL %s k=%0d: sel=%b seg=%h, expected sel=%b seg=%h",
                 name, k, selector, displayout, sel_exp, seg_exp);
      end
      n_tests++;
      if (frame_start !== (k == 0)) begin
        n_fail++;
        $display("FAIL %s frame_start k=%0d: got %b expected %b",
                 name, k, frame_start, (k == 0));
      end
      if (inject_k >= 0) begin
        if (k == inject_k) begin
          expect_ready({name, " ready before offer"}, 1'b1);
          frame_in    = inj_frame;
          frame_valid = 1'b1;
        end
        if (k == inject_k + 1) begin
          expect_ready({name, " ready after transfer"}, 1'b0);
          frame_valid = 1'b0;
        end
        if (k == FRAME - 2) expect_ready({name, " ready before boundary"}, 1'b0);
        if (k == FRAME - 1) expect_ready({name, " ready after boundary"}, 1'b1);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    enable      = 1'b0;
    frame_valid = 1'b0;
    frame_in    = '0;
    blank_mask  = 4'b0000;
    brightness  = 4'd15;
    tick();
    tick();
    expect_idle("reset outputs");
    expect_ready("reset ready", 1'b1);
  endtask

  task automatic test_scan();
    rst         = 1'b0;
    frame_in    = FRAME_A;
    frame_valid = 1'b1;
    tick();
    expect_ready("scan load ready low", 1'b0);
    frame_valid = 1'b0;
    tick();
    expect_ready("scan load applied", 1'b1);
    enable = 1'b1;
    tick();
    expect_fs("scan first frame_start");
    check_frame(pats_a, 15, 4'b0000, -1, '0, "scan frame1");
    check_frame(pats_a, 15, 4'b0000, -1, '0, "scan frame2");
  endtask

  task automatic test_dim();
    brightness = 4'd0;
    wait_frame_start("dim0 wait");
    check_frame(pats_a, 0, 4'b0000, -1, '0, "dim bri0");
    brightness = 4'd1;
    wait_frame_start("dim1 wait");
    check_frame(pats_a, 1, 4'b0000, -1, '0, "dim bri1");
    brightness = 4'd15;
  endtask

  task automatic test_back_to_back();
    wait_frame_start("b2b wait");
    check_frame(pats_a, 15, 4'b0000, 20, FRAME_B, "b2b old frame");
    check_frame(pats_b, 15, 4'b0000, -1, '0, "b2b new frame");
  endtask

  task automatic test_blank_mask();
    blank_mask = 4'b0100;
    wait_frame_start("mask wait");
    check_frame(pats_b, 15, 4'b0100, -1, '0, "mask digit2");
    blank_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    wait_frame_start("rstmid wait");
    for (int i = 0; i < 30; i++) tick();
    expect_ready("rstmid ready before offer", 1'b1);
    frame_in    = FRAME_A;
    frame_valid = 1'b1;
    tick();
    expect_ready("rstmid pending taken", 1'b0);
    frame_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    n_tests++;
    if (selector !== 4'b0100 || displayout !== ~pats_b[2]) begin
      n_fail++;
      $display("FAIL rstmid digit2 on: sel=%b seg=%h expected sel=0100 seg=%h",
               selector, displayout, ~pats_b[2]);
    end
    rst = 1'b1;
    tick();
    expect_idle("rstmid outputs");
    expect_ready("rstmid ready", 1'b1);
    rst = 1'b0;
    tick();
    expect_fs("rstmid restart frame_start");
    check_frame(pats_0, 15, 4'b0000, -1, '0, "rstmid blank frame1");
    check_frame(pats_0, 15, 4'b0000, -1, '0, "rstmid pending dropped");
  endtask

  task automatic test_enable();
    enable = 1'b0;
    tick();
    expect_idle("disable outputs");
    frame_in    = FRAME_C;
    frame_valid = 1'b1;
    tick();
    expect_ready("disable load ready low", 1'b0);
    expect_idle("disable outputs 2");
    frame_valid = 1'b0;
    tick();
    expect_ready("disable load applied", 1'b1);
    expect_idle("disable outputs 3");
    enable = 1'b1;
    tick();
    expect_fs("enable frame_start");
    check_frame(pats_c, 15, 4'b0000, -1, '0, "enable new frame");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_dim();
    test_back_to_back();
    test_blank_mask();
    test_reset_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
